// File: rtl/sm_slice_scheduler_if.sv
// Scheduler <-> pipeline / swap-engine bundle.
// master : the scheduler (drives sm_o, swap_req_o, swap_to_o, stall_run_o,
//          idle_o, swap_cnt_o; samples stall/enable/slice/safe/yield/done).
// slave  : the surrounding pipeline and swap engine (opposite directions).
interface sm_slice_scheduler_if #(
  parameter int N_SM   = 8,
  parameter int SM_W   = 3,
  parameter int GRAN_W = 8,
  parameter int CNT_W  = 16
);
  logic              stall_i;
  logic [N_SM-1:0]   sm_en_i;
  logic [GRAN_W-1:0] granu_i;
  logic              safe_i;
  logic              yield_i;
  logic              swap_done_i;
  logic [SM_W-1:0]   sm_o;
  logic              swap_req_o;
  logic [SM_W-1:0]   swap_to_o;
  logic              stall_run_o;
  logic              idle_o;
  logic [CNT_W-1:0]  swap_cnt_o;

  modport master (
    input  stall_i, sm_en_i, granu_i, safe_i, yield_i, swap_done_i,
    output sm_o, swap_req_o, swap_to_o, stall_run_o, idle_o, swap_cnt_o
  );

  modport slave (
    output stall_i, sm_en_i, granu_i, safe_i, yield_i, swap_done_i,
    input  sm_o, swap_req_o, swap_to_o, stall_run_o, idle_o, swap_cnt_o
  );
endinterface

// File: rtl/sm_slice_scheduler.sv
// Time-slice scheduler sharing one SIMD pipeline among N_SM contexts.
// Runs the active SM for granu_i+1 unstalled cycles (or until yield / disable),
// waits for a pipeline safe point, then requests a context swap to the next
// enabled SM in round-robin order and holds the request until swap_done_i.
// Ports: clk, reset (sync, active-high), bus (master side of
// sm_slice_scheduler_if). All outputs are registered.
module sm_slice_scheduler #(
  parameter int N_SM   = 8,
  parameter int SM_W   = 3,
  parameter int GRAN_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  sm_slice_scheduler_if.master    bus
);

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWAP} state_t;

  state_t            state_q, state_d;
  logic [SM_W-1:0]   sm_q, sm_d;
  logic [GRAN_W-1:0] cnt_q, cnt_d;
  logic              req_q, req_d;
  logic [SM_W-1:0]   to_q, to_d;
  logic              stall_run_q, stall_run_d;
  logic              idle_q, idle_d;
  logic [CNT_W-1:0]  swap_cnt_q, swap_cnt_d;

  // Candidate k is the SM at round-robin distance k+1 from the active one.
  // The wrap is done by subtraction so non-power-of-two N_SM never yields
  // an out-of-range index.
  logic [N_SM-2:0] cand;
  logic [SM_W-1:0] cand_idx [N_SM-1];

  genvar gi;
  generate
    for (gi = 0; gi < N_SM - 1; gi++) begin : g_cand
      logic [SM_W:0] sum;
      assign sum = {1'b0, sm_q} + (SM_W + 1)'(gi + 1);
      assign cand_idx[gi] = (sum >= (SM_W + 1)'(N_SM))
                          ? SM_W'(sum - (SM_W + 1)'(N_SM))
                          : sum[SM_W-1:0];
      assign cand[gi] = bus.sm_en_i[cand_idx[gi]];
    end
  endgenerate

  // Nearest enabled candidate wins: scan from far to near so the last hit
  // written is the closest one.
  logic            found;
  logic [SM_W-1:0] next_idx;

  always_comb begin
    found    = 1'b0;
    next_idx = '0;
    for (int k = N_SM - 2; k >= 0; k--) begin
      if (cand[k]) begin
        found    = 1'b1;
        next_idx = cand_idx[k];
      end
    end
  end

  logic cur_en, expire, eval, take_swap, no_target;

  always_comb begin
    cur_en    = bus.sm_en_i[sm_q];
    expire    = (cnt_q >= bus.granu_i) | bus.yield_i | ~cur_en;
    // Selection is evaluated on an unstalled expiring RUN cycle and on every
    // unstalled DRAIN cycle (mask may change while draining).
    eval      = ~bus.stall_i & (((state_q == ST_RUN) & expire) | (state_q == ST_DRAIN));
    take_swap = eval & found & bus.safe_i;
    no_target = eval & ~found;
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_RUN;
      sm_q        <= '0;
      cnt_q       <= '0;
      req_q       <= 1'b0;
      to_q        <= '0;
      stall_run_q <= 1'b0;
      idle_q      <= 1'b0;
      swap_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      sm_q        <= sm_d;
      cnt_q       <= cnt_d;
      req_q       <= req_d;
      to_q        <= to_d;
      stall_run_q <= stall_run_d;
      idle_q      <= idle_d;
      swap_cnt_q  <= swap_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN, ST_DRAIN: begin
        if (take_swap)          state_d = ST_SWAP;
        else if (no_target)     state_d = ST_RUN;
        else if (eval && found) state_d = ST_DRAIN;
      end
      ST_SWAP: begin
        if (bus.swap_done_i) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    sm_d        = sm_q;
    cnt_d       = cnt_q;
    req_d       = req_q;
    to_d        = to_q;
    stall_run_d = stall_run_q;
    // idle drops as soon as any SM is enabled, whatever the state.
    idle_d      = idle_q & ~(|bus.sm_en_i);
    swap_cnt_d  = swap_cnt_q;

    if ((state_q == ST_RUN) && !bus.stall_i && !expire) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (no_target) begin
      cnt_d = '0;
      if (!cur_en) idle_d = 1'b1;
    end
    if (take_swap) begin
      to_d        = next_idx;
      req_d       = 1'b1;
      stall_run_d = 1'b1;
    end
    if ((state_q == ST_SWAP) && bus.swap_done_i) begin
      sm_d        = to_q;
      cnt_d       = '0;
      req_d       = 1'b0;
      stall_run_d = 1'b0;
      if (swap_cnt_q != {CNT_W{1'b1}}) swap_cnt_d = swap_cnt_q + 1'b1;
    end
  end

  assign bus.sm_o        = sm_q;
  assign bus.swap_req_o  = req_q;
  assign bus.swap_to_o   = to_q;
  assign bus.stall_run_o = stall_run_q;
  assign bus.idle_o      = idle_q;
  assign bus.swap_cnt_o  = swap_cnt_q;

endmodule

// File: tb/tb_sm_slice_scheduler.sv
module tb_sm_slice_scheduler;

  localparam int N_SM   = 8;
  localparam int SM_W   = 3;
  localparam int GRAN_W = 8;
  localparam int CNT_W  = 4;

  logic clk;
  logic reset;

  sm_slice_scheduler_if #(.N_SM(N_SM), .SM_W(SM_W), .GRAN_W(GRAN_W), .CNT_W(CNT_W)) bus ();

  sm_slice_scheduler #(.N_SM(N_SM), .SM_W(SM_W), .GRAN_W(GRAN_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       stall;
    logic [7:0] en;
    logic [7:0] gran;
    logic       safe;
    logic       yld;
    logic       done;
    logic [2:0] sm;
    logic       req;
    logic [2:0] to;
    logic       sr;
    logic       idle;
    logic [3:0] scnt;
  } vec_t;

  vec_t vq[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [2:0] sm, input logic req,
                         input logic [2:0] to, input logic sr, input logic idle,
                         input logic [3:0] scnt);
    chk({tag, ".sm"},       32'(bus.sm_o),        32'(sm));
    chk({tag, ".req"},      32'(bus.swap_req_o),  32'(req));
    chk({tag, ".to"},       32'(bus.swap_to_o),   32'(to));
    chk({tag, ".stall_run"},32'(bus.stall_run_o), 32'(sr));
    chk({tag, ".idle"},     32'(bus.idle_o),      32'(idle));
    chk({tag, ".swap_cnt"}, 32'(bus.swap_cnt_o),  32'(scnt));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    chk_all("reset", 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
    reset = 1'b0;
  endtask

  task automatic set_in(input logic stall, input logic [7:0] en, input logic [7:0] gran,
                        input logic safe, input logic yld, input logic done);
    bus.stall_i     = stall;
    bus.sm_en_i     = en;
    bus.granu_i     = gran;
    bus.safe_i      = safe;
    bus.yield_i     = yld;
    bus.swap_done_i = done;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    set_in(1'b0, 8'hFF, 8'd0, 1'b1, 1'b0, 1'b0);

    // ---- Table: skip, mask change, done-outside-swap, yield, single SM, idle
    //          stall  en     gran    safe yld done  sm  req to  sr idle scnt
    vq.push_back('{1'b0, 8'hA5, 8'd1,   1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0});
    vq.push_back('{1'b0, 8'hA5, 8'd1,   1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd2, 1'b1, 1'b0, 4'd0});
    vq.push_back('{1'b0, 8'hA5, 8'd1,   1'b1, 1'b0, 1'b1, 3'd2, 1'b0, 3'd2, 1'b0, 1'b0, 4'd1});
    vq.push_back('{1'b0, 8'hA5, 8'd1,   1'b1, 1'b0, 1'b0, 3'd2, 1'b0, 3'd2, 1'b0, 1'b0, 4'd1});
    vq.push_back('{1'b0, 8'hA5, 8'd1,   1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 3'd5, 1'b1, 1'b0, 4'd1});
    vq.push_back('{1'b0, 8'hA5, 8'd1,   1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 3'd5, 1'b0, 1'b0, 4'd2});
    vq.push_back('{1'b0, 8'hA5, 8'd1,   1'b1, 1'b0, 1'b0, 3'd5, 1'b0, 3'd5, 1'b0, 1'b0, 4'd2});
    vq.push_back('{1'b0, 8'hA5, 8'd1,   1'b1, 1'b0, 1'b0, 3'd5, 1'b1, 3'd7, 1'b1, 1'b0, 4'd2});
    vq.push_back('{1'b0, 8'hA5, 8'd1,   1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 3'd7, 1'b0, 1'b0, 4'd3});
    vq.push_back('{1'b0, 8'hA5, 8'd1,   1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 3'd7, 1'b0, 1'b0, 4'd3});
    vq.push_back('{1'b0, 8'hA5, 8'd1,   1'b1, 1'b0, 1'b0, 3'd7, 1'b1, 3'd0, 1'b1, 1'b0, 4'd3});
    vq.push_back('{1'b0, 8'hA5, 8'd1,   1'b1, 1'b0, 1'b1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd4});
    vq.push_back('{1'b0, 8'hA1, 8'd1,   1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd4});
    vq.push_back('{1'b0, 8'hA1, 8'd1,   1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd5, 1'b1, 1'b0, 4'd4});
    vq.push_back('{1'b0, 8'hA1, 8'd1,   1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 3'd5, 1'b0, 1'b0, 4'd5});
    vq.push_back('{1'b0, 8'hA1, 8'd1,   1'b1, 1'b0, 1'b1, 3'd5, 1'b0, 3'd5, 1'b0, 1'b0, 4'd5});
    vq.push_back('{1'b0, 8'hA1, 8'd200, 1'b1, 1'b1, 1'b0, 3'd5, 1'b1, 3'd7, 1'b1, 1'b0, 4'd5});
    vq.push_back('{1'b0, 8'hA1, 8'd200, 1'b1, 1'b0, 1'b1, 3'd7, 1'b0, 3'd7, 1'b0, 1'b0, 4'd6});
    vq.push_back('{1'b0, 8'h80, 8'd200, 1'b1, 1'b1, 1'b0, 3'd7, 1'b0, 3'd7, 1'b0, 1'b0, 4'd6});
    vq.push_back('{1'b0, 8'h80, 8'd0,   1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 3'd7, 1'b0, 1'b0, 4'd6});
    vq.push_back('{1'b0, 8'h00, 8'd0,   1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 3'd7, 1'b0, 1'b1, 4'd6});
    vq.push_back('{1'b0, 8'h00, 8'd0,   1'b1, 1'b0, 1'b0, 3'd7, 1'b0, 3'd7, 1'b0, 1'b1, 4'd6});
    vq.push_back('{1'b0, 8'h10, 8'd0,   1'b1, 1'b0, 1'b0, 3'd7, 1'b1, 3'd4, 1'b1, 1'b0, 4'd6});
    vq.push_back('{1'b0, 8'h10, 8'd0,   1'b1, 1'b0, 1'b1, 3'd4, 1'b0, 3'd4, 1'b0, 1'b0, 4'd7});
    vq.push_back('{1'b1, 8'h10, 8'd0,   1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 3'd4, 1'b0, 1'b0, 4'd7});
    vq.push_back('{1'b0, 8'h10, 8'd0,   1'b1, 1'b0, 1'b0, 3'd4, 1'b0, 3'd4, 1'b0, 1'b0, 4'd7});

    do_reset();
    for (int i = 0; i < vq.size(); i++) begin
      set_in(vq[i].stall, vq[i].en, vq[i].gran, vq[i].safe, vq[i].yld, vq[i].done);
      tick();
      $display("vec %0d: en=%h g=%0d sm=%0d req=%0d to=%0d idle=%0d cnt=%0d", i,
               vq[i].en, vq[i].gran, bus.sm_o, bus.swap_req_o, bus.swap_to_o,
               bus.idle_o, bus.swap_cnt_o);
      chk_all($sformatf("vec%0d", i), vq[i].sm, vq[i].req, vq[i].to, vq[i].sr,
              vq[i].idle, vq[i].scnt);
    end

    // ---- Rotation: full lap, G=3, done two cycles after request
    do_reset();
    set_in(1'b0, 8'hFF, 8'd3, 1'b1, 1'b0, 1'b0);
    for (int s = 0; s < 8; s++) begin
      chk("rot_sm_start", 32'(bus.sm_o), 32'(s));
      n = 0;
      do begin
        tick();
        n++;
      end while (!bus.swap_req_o && n < 50);
      chk("rot_slice_len", 32'(n), 32'd4);
      chk("rot_to", 32'(bus.swap_to_o), 32'((s + 1) % 8));
      tick();
      chk("rot_req_hold", 32'(bus.swap_req_o), 32'd1);
      chk("rot_to_hold", 32'(bus.swap_to_o), 32'((s + 1) % 8));
      bus.swap_done_i = 1'b1;
      tick();
      bus.swap_done_i = 1'b0;
      $display("rot slot %0d: len=%0d new_sm=%0d cnt=%0d", s, n, bus.sm_o, bus.swap_cnt_o);
      chk("rot_sm_new", 32'(bus.sm_o), 32'((s + 1) % 8));
      chk("rot_req_clr", 32'(bus.swap_req_o), 32'd0);
      chk("rot_stall_run_clr", 32'(bus.stall_run_o), 32'd0);
    end
    chk("rot_swap_cnt", 32'(bus.swap_cnt_o), 32'd8);

    // ---- Safe-point hold: G=2, safe low through expiry, stall during DRAIN
    set_in(1'b0, 8'hFF, 8'd2, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("drain_no_req", 32'(bus.swap_req_o), 32'd0);
    end
    bus.stall_i = 1'b1;
    bus.safe_i  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("drain_stall_no_req", 32'(bus.swap_req_o), 32'd0);
    end
    bus.stall_i = 1'b0;
    tick();
    $display("drain release: req=%0d to=%0d", bus.swap_req_o, bus.swap_to_o);
    chk("drain_req", 32'(bus.swap_req_o), 32'd1);
    chk("drain_to", 32'(bus.swap_to_o), 32'd1);
    chk("drain_stall_run", 32'(bus.stall_run_o), 32'd1);
    bus.swap_done_i = 1'b1;
    tick();
    bus.swap_done_i = 1'b0;
    chk("drain_sm_new", 32'(bus.sm_o), 32'd1);

    // ---- Saturation: 20 swaps with CNT_W=4, then reset mid-SWAP
    do_reset();
    set_in(1'b0, 8'hFF, 8'd0, 1'b1, 1'b0, 1'b1);
    repeat (30) tick();
    chk("sat_15", 32'(bus.swap_cnt_o), 32'd15);
    repeat (10) tick();
    $display("sat: swap_cnt=%0d", bus.swap_cnt_o);
    chk("sat_hold", 32'(bus.swap_cnt_o), 32'd15);
    bus.swap_done_i = 1'b0;
    tick();
    chk("pre_reset_req", 32'(bus.swap_req_o), 32'd1);
    chk("pre_reset_stall_run", 32'(bus.stall_run_o), 32'd1);
    reset = 1'b1;
    tick();
    $display("reset mid-swap: req=%0d cnt=%0d", bus.swap_req_o, bus.swap_cnt_o);
    chk_all("reset_midswap", 3'd0, 1'b0, 3'd0, 1'b0, 1'b0, 4'd0);
    reset = 1'b0;

    // ---- Yield at cnt=10 with G=200, mask 0x03
    set_in(1'b0, 8'h03, 8'd200, 1'b1, 1'b0, 1'b0);
    repeat (10) tick();
    chk("yield_pre_req", 32'(bus.swap_req_o), 32'd0);
    bus.yield_i = 1'b1;
    tick();
    bus.yield_i = 1'b0;
    $display("yield: req=%0d to=%0d", bus.swap_req_o, bus.swap_to_o);
    chk("yield_req", 32'(bus.swap_req_o), 32'd1);
    chk("yield_to", 32'(bus.swap_to_o), 32'd1);
    bus.swap_done_i = 1'b1;
    tick();
    bus.swap_done_i = 1'b0;
    chk("yield_sm", 32'(bus.sm_o), 32'd1);
    chk("yield_cnt", 32'(bus.swap_cnt_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
